serial_magnitude_comparator: RTL

SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

---
 rtl/serial_magnitude_comparator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//   Unsigned magnitude compare of two WIDTH-bit operands, resolved one bit per
//   clock from the MSB down. The compare stops at the first differing bit, so
//   latency is k cycles, where k is the 1-based position of that bit from the
//   MSB (k = WIDTH when the operands are equal).
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active high
//   start        begin a compare (accepted only in IDLE)
//   a, b         operands, captured when start is accepted
//   busy         high in COMPARE and DONE
//   done         one-cycle pulse, result valid
//   gt, lt, eq   result flags, held until the next accepted start
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; result flags hold the last result
// COMPARE | examining the MSBs of the shift registers, one bit per cycle
// DONE    | result just registered; done pulse, back to IDLE next edge
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic a_msb;
    logic b_msb;

    assign a_msb = sh_a_q[WIDTH-1];
    assign b_msb = sh_b_q[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_a_d  = a;
                    sh_b_d  = b;
                    cnt_d   = CNT_W'(WIDTH);
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (a_msb && !b_msb) begin
                    gt_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (!a_msb && b_msb) begin
                    lt_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(1)) begin
                    // last bit also matched: operands are equal
                    eq_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    sh_a_d = sh_a_q << 1;
                    sh_b_d = sh_b_q << 1;
                    cnt_d  = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule
